// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin arbiter sharing one FIFO push port among N requesters
module fifo_push_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 2,
  parameter int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  input  logic [N*WIDTH-1:0] req_data,
  output logic [N-1:0]       req_ready,
  output logic               push_valid,
  output logic [WIDTH-1:0]   push_data,
  input  logic               push_ready,
  output logic               grant_valid,
  output logic [IW-1:0]      grant_idx,
  output logic [15:0]        xfer_count
);

  localparam logic [IW-1:0] LAST_REQ   = IW'(N - 1);
  localparam logic [3:0]    BURST_LAST = 4'(MAX_BURST - 1);

  logic [IW-1:0] last_idx;
  logic          hold;
  logic [IW-1:0] held_idx;
  logic [3:0]    burst_cnt;

  logic          held_ok;
  logic [IW-1:0] base_idx;
  logic          xfer;

  assign held_ok = hold && req_valid[held_idx];

  // A stale lock (held requester dropped valid) rotates from the held requester.
  assign base_idx = hold ? held_idx : last_idx;

  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    if (held_ok) begin
      grant_valid = 1'b1;
      grant_idx   = held_idx;
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = (int'(base_idx) + k) % N;
        if (!grant_valid && req_valid[j]) begin
          grant_valid = 1'b1;
          grant_idx   = j[IW-1:0];
        end
      end
    end
  end

  always_comb begin
    push_data = '0;
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_valid && grant_idx == i[IW-1:0]) begin
        push_data    = req_data[i*WIDTH +: WIDTH];
        req_ready[i] = push_ready;
      end
    end
  end

  assign push_valid = grant_valid;
  assign xfer       = push_valid && push_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_idx   <= LAST_REQ;
      hold       <= 1'b0;
      held_idx   <= '0;
      burst_cnt  <= '0;
      xfer_count <= '0;
    end else if (xfer) begin
      xfer_count <= xfer_count + 16'd1;
      if (burst_cnt == BURST_LAST) begin
        last_idx  <= grant_idx;
        hold      <= 1'b0;
        burst_cnt <= '0;
      end else begin
        hold      <= 1'b1;
        held_idx  <= grant_idx;
        burst_cnt <= burst_cnt + 4'd1;
      end
    end else if (grant_valid) begin
      // FIFO stalled: lock the grant so push_valid/push_data stay stable.
      hold     <= 1'b1;
      held_idx <= grant_idx;
    end else if (hold && !req_valid[held_idx]) begin
      hold      <= 1'b0;
      last_idx  <= held_idx;
      burst_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - scoreboard bench for fifo_push_arbiter
module tb_fifo_push_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        push_valid;
  logic [7:0]  push_data;
  logic        push_ready;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [15:0] xfer_count;

  logic [7:0]  dat [4];
  // {valid, idx, data, req_ready}
  logic [14:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  fifo_push_arbiter #(.N(4), .WIDTH(8), .MAX_BURST(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = dat[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: one expectation per stimulus cycle, checked mid-cycle.
  always @(negedge clk) begin
    logic [14:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("push_valid", 32'(push_valid), 32'(e[14]));
      chk("grant_valid", 32'(grant_valid), 32'(e[14]));
      if (e[14]) begin
        chk("grant_idx", 32'(grant_idx), 32'(e[13:12]));
        chk("push_data", 32'(push_data), 32'(e[11:4]));
      end
      chk("req_ready", 32'(req_ready), 32'(e[3:0]));
    end
  end

  // e_idx < 0 means no grant expected this cycle.
  task automatic step(input logic [3:0] v, input logic pr, input int e_idx);
    logic [1:0] ix;
    req_valid  = v;
    push_ready = pr;
    if (e_idx >= 0) begin
      ix = e_idx[1:0];
      exp_q.push_back({1'b1, ix, dat[ix], pr ? (4'b0001 << ix) : 4'b0000});
    end else begin
      exp_q.push_back({1'b0, 2'b00, 8'h00, 4'b0000});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_valid  = '0;
    push_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seq1 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    for (int i = 0; i < 4; i++) dat[i] = 8'hA0 + 8'(i);
    rst_n = 1'b1; req_valid = '0; push_ready = 1'b0;
    #2;
    do_reset();
    chk("rst_push_valid", 32'(push_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_push_data", 32'(push_data), 32'd0);
    step(4'b0000, 1'b1, -1);

    // all valid: bursts of two in rotation
    for (int i = 0; i < 9; i++) step(4'b1111, 1'b1, seq1[i]);
    chk("xfer_count_t1", 32'(xfer_count), 32'd9);

    // lone requester streams
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 2);
    chk("xfer_count_t2", 32'(xfer_count), 32'd14);

    // stall on req1 holds grant and data while req0 arrives
    dat[1] = 8'h3C;
    step(4'b0010, 1'b0, 1);
    step(4'b0011, 1'b0, 1);
    step(4'b0011, 1'b0, 1);
    chk("xfer_count_stall", 32'(xfer_count), 32'd14);
    step(4'b0011, 1'b1, 1);
    chk("xfer_count_t3", 32'(xfer_count), 32'd15);

    // FIFO full, all valid: locked on req1, nothing accepted
    for (int i = 0; i < 4; i++) step(4'b1111, 1'b0, 1);
    chk("xfer_count_t4", 32'(xfer_count), 32'd15);

    // lock on req3, reset discards it
    do_reset();
    step(4'b1000, 1'b0, 3);
    step(4'b1001, 1'b0, 3);
    do_reset();
    step(4'b1001, 1'b1, 0);
    step(4'b1001, 1'b1, 0);
    step(4'b1001, 1'b1, 3);
    chk("xfer_count_t5", 32'(xfer_count), 32'd3);

    // locked req1 drops valid after one beat: rotation moves to req2
    do_reset();
    step(4'b0010, 1'b1, 1);
    step(4'b0100, 1'b1, 2);
    step(4'b0100, 1'b1, 2);
    step(4'b0000, 1'b1, -1);
    chk("xfer_count_t6", 32'(xfer_count), 32'd3);

    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
